// File: rtl/nios2_debug_ocimem_ctrl_pkg.sv
// Shared constants and types for the debug on-chip memory controller.
// jdo field positions, FSM encoding and default geometry.
package nios2_debug_ocimem_ctrl_pkg;

  localparam int JDO_W         = 38;
  localparam int ADDR_LSB      = 2;
  localparam int CLR_ERR_BIT   = 1;
  localparam int RD_NOW_BIT    = 0;
  localparam int WDATA_LSB     = 3;
  localparam int WDATA_W       = 32;
  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_ROM_WORDS = 64;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_JRD_WAIT = 2'd1,
    ST_JRD_ARM  = 2'd2
  } state_e;

endpackage

// File: rtl/nios2_debug_ocimem_ram.sv
// Single-port debug RAM, byte-enabled writes, one-cycle registered read.
// Contents are deliberately not reset.
module nios2_debug_ocimem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/nios2_debug_ocimem_ctrl.sv
// Executes JTAG debug-slave memory commands against the debug RAM,
// sharing the RAM with a CPU Avalon-MM slave port (JTAG has priority).
module nios2_debug_ocimem_ctrl
  import nios2_debug_ocimem_ctrl_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int ROM_WORDS = DEF_ROM_WORDS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  input  logic              avs_debugaccess,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] WR_LIMIT =
    (ADDR_W+1)'(DEPTH - ROM_WORDS);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [31:0]       mon_d_q, mon_d_d;
  logic              rdy_q, rdy_d;
  logic              err_q, err_d;
  logic              cpu_rd_q, cpu_rd_d;
  logic [31:0]       rd_hold_q, rd_hold_d;

  logic              any_take, cmd_ok;
  logic              st_a, st_b, st_n;
  logic              wr_ok, jrd, jwr;
  logic              cpu_go, cpu_wr, cpu_rd;
  logic              ram_we, ram_re;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;
  logic [ADDR_W-1:0] jdo_addr;
  logic [31:0]       jdo_wdata;
  logic              unused_jdo;

  assign jdo_addr   = jdo[ADDR_LSB +: ADDR_W];
  assign jdo_wdata  = jdo[WDATA_LSB +: WDATA_W];
  assign unused_jdo = ^jdo[JDO_W-1:WDATA_LSB+WDATA_W];

  assign any_take = take_action_ocimem_a
                  | take_action_ocimem_b
                  | take_no_action_ocimem_a;

  // The armed read owns the RAM in JRD_ARM, so strobes there are dropped.
  assign cmd_ok = (state_q != ST_JRD_ARM);
  assign st_a = cmd_ok & take_action_ocimem_a;
  assign st_b = cmd_ok & take_action_ocimem_b
              & ~take_action_ocimem_a;
  assign st_n = cmd_ok & take_no_action_ocimem_a
              & ~take_action_ocimem_a
              & ~take_action_ocimem_b;

  assign wr_ok = ({1'b0, mon_a_q} < WR_LIMIT);

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = ST_IDLE;
    unique case (state_q)
      ST_JRD_ARM: state_d = ST_JRD_WAIT;
      ST_IDLE, ST_JRD_WAIT: begin
        if (st_n)
          state_d = ST_JRD_WAIT;
        else if (st_a && jdo[RD_NOW_BIT])
          state_d = ST_JRD_ARM;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    jrd = st_n | (state_q == ST_JRD_ARM);
    jwr = st_b & wr_ok;
    avs_waitrequest = any_take | (state_q != ST_IDLE);
    cpu_go = (avs_read | avs_write) & ~avs_waitrequest;
    cpu_wr = cpu_go & avs_write & avs_debugaccess;
    cpu_rd = cpu_go & avs_read & ~avs_write;
    ram_we = jwr | cpu_wr;
    ram_re = jrd | cpu_rd;
    ram_be = jwr ? 4'hF : avs_byteenable;
    ram_addr = (jwr | jrd) ? mon_a_q : avs_address;
    ram_wdata = jwr ? jdo_wdata : avs_writedata;
  end

  always_comb begin
    mon_a_d   = mon_a_q;
    mon_d_d   = mon_d_q;
    rdy_d     = rdy_q;
    err_d     = err_q;
    cpu_rd_d  = cpu_rd;
    rd_hold_d = cpu_rd_q ? ram_rdata : rd_hold_q;
    if (state_q == ST_JRD_WAIT) begin
      mon_d_d = ram_rdata;
      rdy_d   = 1'b1;
    end
    if (state_q == ST_JRD_ARM)
      mon_a_d = mon_a_q + ADDR_W'(1);
    unique case (1'b1)
      st_a: begin
        mon_a_d = jdo_addr;
        rdy_d   = 1'b0;
        if (jdo[CLR_ERR_BIT]) err_d = 1'b0;
      end
      st_b: begin
        mon_a_d = mon_a_q + ADDR_W'(1);
        rdy_d   = 1'b1;
        if (!wr_ok) err_d = 1'b1;
      end
      st_n: begin
        mon_a_d = mon_a_q + ADDR_W'(1);
        rdy_d   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mon_a_q   <= '0;
      mon_d_q   <= '0;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
      cpu_rd_q  <= 1'b0;
      rd_hold_q <= '0;
    end else begin
      mon_a_q   <= mon_a_d;
      mon_d_q   <= mon_d_d;
      rdy_q     <= rdy_d;
      err_q     <= err_d;
      cpu_rd_q  <= cpu_rd_d;
      rd_hold_q <= rd_hold_d;
    end
  end

  nios2_debug_ocimem_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign avs_readdata  = cpu_rd_q ? ram_rdata : rd_hold_q;
  assign MonDReg       = mon_d_q;
  assign monitor_ready = rdy_q;
  assign monitor_error = err_q;

endmodule

// File: doc/nios2_debug_ocimem_ctrl.md
Name: nios2_debug_ocimem_ctrl

Overview:
Consumes the system-clock command outputs of the debug-slave JTAG stage (jdo plus the take_action_ocimem_a, take_action_ocimem_b and take_no_action_ocimem_a strobes). Executes them against an on-chip debug RAM and returns MonDReg, monitor_ready and monitor_error to that stage for the next JTAG scan. The same RAM is shared with the CPU through an Avalon-MM slave port. JTAG accesses have priority over CPU accesses.

Parameters:
ADDR_W, 8, word-address width; RAM depth is 2**ADDR_W 32-bit words
ROM_WORDS, 64, top ROM_WORDS words are write-protected from JTAG (debug monitor image)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
jdo  in  38  JTAG data-out word, valid while a take_* strobe is high
take_action_ocimem_a  in  1  load address command (single-cycle strobe)
take_action_ocimem_b  in  1  write-data command (single-cycle strobe)
take_no_action_ocimem_a  in  1  read-next command (single-cycle strobe)
avs_address  in  ADDR_W  CPU word address
avs_read  in  1  CPU read request
avs_write  in  1  CPU write request
avs_writedata  in  32  CPU write data
avs_byteenable  in  4  CPU byte enables
avs_debugaccess  in  1  CPU write permission qualifier
avs_readdata  out  32  CPU read data
avs_waitrequest  out  1  CPU stall
MonDReg  out  32  monitor data register returned to the JTAG stage
monitor_ready  out  1  last JTAG command complete
monitor_error  out  1  sticky protection-violation flag

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-low (reset_n). On reset: MonAReg=0, MonDReg=0, monitor_ready=0, monitor_error=0, avs_readdata=0, FSM=IDLE. RAM contents are not reset. Reset during a pending JTAG read aborts it, and MonDReg stays 0.
- Strobe priority if more than one is high in the same cycle: ocimem_a > ocimem_b > no_action_a. Lower-priority strobes are dropped.
- take_action_ocimem_a:
  - MonAReg <= jdo[ADDR_W+1:2].
  - If jdo[1]=1, clear monitor_error.
  - If jdo[0]=1, a read is issued at the new address on the next cycle, with the same timing as no_action_a.
  - monitor_ready <= 0.
- take_action_ocimem_b (cycle N):
  - If MonAReg < 2**ADDR_W-ROM_WORDS, write jdo[34:3] to RAM[MonAReg] with all bytes enabled.
  - Otherwise, no write and monitor_error <= 1.
  - In both cases MonAReg <= MonAReg+1 and monitor_ready=1 from N+1.
- take_no_action_ocimem_a (cycle N):
  - RAM read at MonAReg issued in N; MonAReg <= MonAReg+1.
  - FSM goes IDLE -> JRD_WAIT at N+1, where RAM data is returned and registered into MonDReg.
  - MonDReg and monitor_ready=1 visible from N+2; FSM returns to IDLE.
  - monitor_ready <= 0 at N+1.
- MonAReg wraps from 2**ADDR_W-1 to 0. No error is raised on wrap.
- FSM states: IDLE, JRD_WAIT, JRD_ARM (the one-cycle state entered after ocimem_a with jdo[0]=1, which then issues the read).
- avs_waitrequest is combinational: high when any take_* strobe is high or FSM != IDLE; otherwise low.
- CPU transfers:
  - A transfer is accepted in a cycle where (avs_read|avs_write) & !avs_waitrequest.
  - Read: avs_readdata is valid exactly 1 cycle after acceptance and holds until the next accepted read.
  - Write: byte-enabled and performed only if avs_debugaccess=1; otherwise silently ignored. The ROM region is writable by the CPU when debugaccess=1.
  - Simultaneous avs_read and avs_write: write takes effect, readdata is not updated.
- A JTAG strobe arriving in the same cycle as a CPU request takes the RAM; the CPU request is held off by waitrequest and must be held by the master.
- A new JTAG strobe arriving while FSM=JRD_WAIT is accepted that cycle (the RAM port is free in JRD_WAIT) and the pending read still completes.

Decomposition:
- Shared package: jdo field constants (ADDR_LSB=2, CLR_ERR_BIT=1, RD_NOW_BIT=0, WDATA_LSB=3, WDATA_W=32), FSM state enum, default ADDR_W/ROM_WORDS.
- One sub-module: nios2_debug_ocimem_ram. Single-port, 2**ADDR_W x 32, byte-enabled, one-cycle synchronous read, no reset.
- Arbitration mux, address counter and FSM stay in the top module.

Test Plan:
- ocimem_a jdo[9:2]=0x10 -> ocimem_b data 0xDEADBEEF -> ocimem_a addr 0x10, jdo[0]=1 -> MonDReg=0xDEADBEEF, monitor_ready=1 two cycles after the read issues, MonAReg=0x11.
- MonAReg=0xFF, issue no_action_a -> read RAM[0xFF], MonAReg wraps to 0x00.
- ocimem_b at address 0xC0 (ROM region, ROM_WORDS=64) -> RAM unchanged, monitor_error=1. Then ocimem_a with jdo[1]=1 -> monitor_error=0.
- CPU write 0x12345678 at 0x05 with byteenable=4'b0011, debugaccess=1 -> CPU read 0x05 gives 0x????5678 (upper bytes unchanged). The same write with debugaccess=0 leaves the word unchanged.
- CPU read held high while a take_action_ocimem_b strobe fires -> waitrequest=1 that cycle. The read is accepted next cycle and readdata returns one cycle later with post-write data if the addresses match.
- Assert reset_n=0 during JRD_WAIT -> MonDReg=0, monitor_ready=0, FSM=IDLE, waitrequest=0 on the cycle after reset.
